// File: rtl/flash_arbiter_if.sv
// flash_arbiter_if
//   Bundles the two requester ports (A: CPU ROM fetch, B: loader DMA) and
//   the DSPI flash read engine handshake into a single interface.
//   slave  : view used by flash_arbiter (takes requests, drives the engine)
//   master : view used by the surrounding glue / engine model
// Signals:
//   flash_ready, flash_busy, flash_dout  engine status and read data
//   flash_addr, flash_cs                 engine word address and start strobe
//   a_req, a_addr, a_ack, a_data         port A level request / ack pulse / data
//   b_req, b_addr, b_ack, b_data         port B, same as port A
interface flash_arbiter_if;
  logic        flash_ready;
  logic        flash_busy;
  logic [15:0] flash_dout;
  logic [21:0] flash_addr;
  logic        flash_cs;

  logic        a_req;
  logic [21:0] a_addr;
  logic        a_ack;
  logic [15:0] a_data;

  logic        b_req;
  logic [21:0] b_addr;
  logic        b_ack;
  logic [15:0] b_data;

  modport slave (
    input  flash_ready, flash_busy, flash_dout,
    input  a_req, a_addr, b_req, b_addr,
    output flash_addr, flash_cs,
    output a_ack, a_data, b_ack, b_data
  );

  modport master (
    output flash_ready, flash_busy, flash_dout,
    output a_req, a_addr, b_req, b_addr,
    input  flash_addr, flash_cs,
    input  a_ack, a_data, b_ack, b_data
  );
endinterface

// File: rtl/flash_arbiter.sv
// flash_arbiter
//   Shares one DSPI flash read engine between port A (CPU ROM fetch) and
//   port B (loader DMA). Sequences the engine's edge-triggered cs/busy
//   protocol, retries starts the engine never acknowledges, and returns
//   16-bit words over a per-port req/ack handshake.
// Ports:
//   clk        clock, same domain as the flash engine
//   resetn     asynchronous, active-low reset
//   bus        flash_arbiter_if.slave (requester ports + engine handshake)
//   grant_b    1 = current or last transaction belongs to port B
//   retry_cnt  saturating count of start timeouts
// Parameters:
//   FAIR           1 = round-robin on ties, 0 = port A always wins
//   START_TIMEOUT  cycles to wait for flash_busy after raising flash_cs
//   GAP_CYCLES     minimum cycles flash_cs stays low between starts (>= 2)
// Optional feature:
//   FLASH_ARB_CACHE_EN  one-entry per-port read cache (tag + valid); the
//                       cached word is the port's own data register.
module flash_arbiter #(
  parameter int FAIR          = 1,
  parameter int START_TIMEOUT = 8,
  parameter int GAP_CYCLES    = 2
) (
  input  logic           clk,
  input  logic           resetn,
  flash_arbiter_if.slave bus,
  output logic           grant_b,
  output logic [7:0]     retry_cnt
);

  typedef enum logic [1:0] {S_GAP, S_IDLE, S_START, S_RUN} state_t;

  state_t     state, state_nxt;
  logic [7:0] gap_cnt;
  logic [7:0] timer;
  logic       retry_pend;
  logic       prio_b;

  logic a_pend, b_pend, sel_b;
  logic hit_a, hit_b;
  logic start_new, retry_go, timeout, done;

  // A request raised during its own ack cycle belongs to the completed
  // transaction; only a req still high afterwards is a new request.
  assign a_pend = bus.a_req && !bus.a_ack;
  assign b_pend = bus.b_req && !bus.b_ack;

  always_comb begin
    sel_b = 1'b0;
    if (a_pend && b_pend) sel_b = (FAIR != 0) ? prio_b : 1'b0;
    else                  sel_b = b_pend;
  end

`ifdef FLASH_ARB_CACHE_EN
  logic [21:0] a_tag, b_tag;
  logic        a_vld, b_vld;

  assign hit_a = (state == S_IDLE) && !retry_pend && a_pend && a_vld && (bus.a_addr == a_tag);
  assign hit_b = (state == S_IDLE) && !retry_pend && b_pend && b_vld && (bus.b_addr == b_tag);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_vld <= 1'b0;
      b_vld <= 1'b0;
      a_tag <= '0;
      b_tag <= '0;
    end else if (done) begin
      if (grant_b) begin
        b_tag <= bus.flash_addr;
        b_vld <= 1'b1;
      end else begin
        a_tag <= bus.flash_addr;
        a_vld <= 1'b1;
      end
    end
  end
`else
  assign hit_a = 1'b0;
  assign hit_b = 1'b0;
`endif

  // A retried start reuses the registered grant; cache hits defer any new
  // flash start to a later IDLE cycle.
  assign start_new = (state == S_IDLE) && !retry_pend && !hit_a && !hit_b &&
                     bus.flash_ready && (a_pend || b_pend);
  assign retry_go  = (state == S_IDLE) && retry_pend && bus.flash_ready;
  assign timeout   = (state == S_START) && !bus.flash_busy &&
                     (timer == 8'(START_TIMEOUT - 1));
  assign done      = (state == S_RUN) && !bus.flash_busy;

  always_comb begin
    state_nxt = state;
    case (state)
      S_GAP:   if (gap_cnt <= 8'd1) state_nxt = S_IDLE;
      S_IDLE:  if (start_new || retry_go) state_nxt = S_START;
      S_START: begin
        if (bus.flash_busy) state_nxt = S_RUN;
        else if (timeout)   state_nxt = S_GAP;
      end
      S_RUN:   if (done) state_nxt = S_GAP;
      default: state_nxt = S_GAP;
    endcase
  end

  // Decoded straight from the state register so reset drops it at once.
  assign bus.flash_cs = (state == S_START);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= S_GAP;
      gap_cnt        <= 8'(GAP_CYCLES);
      timer          <= '0;
      retry_pend     <= 1'b0;
      prio_b         <= 1'b0;
      grant_b        <= 1'b0;
      retry_cnt      <= '0;
      bus.flash_addr <= '0;
      bus.a_ack      <= 1'b0;
      bus.b_ack      <= 1'b0;
      bus.a_data     <= '0;
      bus.b_data     <= '0;
    end else begin
      state <= state_nxt;

      if (state != S_GAP && state_nxt == S_GAP) gap_cnt <= 8'(GAP_CYCLES);
      else if (state == S_GAP)                  gap_cnt <= gap_cnt - 8'd1;

      timer <= (state == S_START) ? timer + 8'd1 : 8'd0;

      if (start_new) begin
        bus.flash_addr <= sel_b ? bus.b_addr : bus.a_addr;
        grant_b        <= sel_b;
      end

      if (timeout) begin
        retry_pend <= 1'b1;
        if (retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
      end else if (retry_go) begin
        retry_pend <= 1'b0;
      end

      bus.a_ack <= hit_a;
      bus.b_ack <= hit_b;

      if (done) begin
        if (grant_b) begin
          bus.b_ack  <= 1'b1;
          bus.b_data <= bus.flash_dout;
        end else begin
          bus.a_ack  <= 1'b1;
          bus.a_data <= bus.flash_dout;
        end
        prio_b <= ~grant_b;
      end
    end
  end

endmodule

// File: tb/tb_flash_arbiter.sv
// tb_flash_arbiter
//   Directed bench for flash_arbiter. Two DUTs run side by side: u[0] with
//   FAIR=1 and u[1] with FAIR=0, each with its own engine model. The model
//   registers a start on a cs rising edge, raises busy 3 cycles later for
//   4 cycles, and presents data on the busy fall. It can be told to ignore
//   the next start. Engine data: 0x000123 -> 0xBEEF, else addr[15:0]^0x5A5A.
module tb_flash_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic ready = 1'b1;

  logic        a_req [2];
  logic        b_req [2];
  logic [21:0] a_addr [2];
  logic [21:0] b_addr [2];
  int          ignore_upto [2];

  logic        cs_w [2];
  logic        a_ack_w [2];
  logic        b_ack_w [2];
  logic        grant_w [2];
  logic        busy_w [2];
  logic [15:0] a_data_w [2];
  logic [15:0] b_data_w [2];
  logic [21:0] addr_w [2];
  logic [7:0]  retry_w [2];
  int          rises_w [2];
  int          aacks_w [2];
  int          starts_w [2];
  int          viol_w [2];
  logic [5:0]  order_w [2];

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] edata(input logic [21:0] addr);
    if (addr == 22'h000123) return 16'hBEEF;
    return addr[15:0] ^ 16'h5A5A;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    flash_arbiter_if bus();
    logic        grant_l;
    logic [7:0]  retry_l;
    logic        busy_m = 1'b0;
    logic [15:0] dout_m = '0;
    logic [21:0] eaddr = '0;
    logic        cs_q = 1'b0;
    int          cnt = 0;
    int          starts = 0;
    int          rises = 0;
    int          aacks = 0;
    int          low_run = 100;
    int          viol = 0;
    logic [5:0]  ord = '0;

    flash_arbiter #(.FAIR(g == 0 ? 1 : 0), .START_TIMEOUT(8), .GAP_CYCLES(2)) dut (
      .clk(clk), .resetn(resetn), .bus(bus), .grant_b(grant_l), .retry_cnt(retry_l)
    );

    assign bus.flash_ready = ready;
    assign bus.flash_busy  = busy_m;
    assign bus.flash_dout  = dout_m;
    assign bus.a_req  = a_req[g];
    assign bus.a_addr = a_addr[g];
    assign bus.b_req  = b_req[g];
    assign bus.b_addr = b_addr[g];

    always @(posedge clk) begin
      cs_q    <= bus.flash_cs;
      low_run <= bus.flash_cs ? 0 : low_run + 1;
      if (bus.flash_cs && !cs_q) begin
        rises <= rises + 1;
        if (low_run < 2) viol <= viol + 1;
      end
      if (bus.a_ack) begin
        aacks <= aacks + 1;
        ord   <= {ord[3:0], 2'b01};
      end else if (bus.b_ack) begin
        ord   <= {ord[3:0], 2'b10};
      end
      if (cnt != 0) begin
        cnt <= cnt + 1;
        if (cnt == 3) busy_m <= 1'b1;
        if (cnt == 7) begin
          busy_m <= 1'b0;
          dout_m <= edata(eaddr);
          cnt    <= 0;
        end
      end else if (bus.flash_cs && !cs_q) begin
        starts <= starts + 1;
        if (starts >= ignore_upto[g]) begin
          cnt   <= 1;
          eaddr <= bus.flash_addr;
        end
      end
    end

    assign cs_w[g]     = bus.flash_cs;
    assign a_ack_w[g]  = bus.a_ack;
    assign b_ack_w[g]  = bus.b_ack;
    assign a_data_w[g] = bus.a_data;
    assign b_data_w[g] = bus.b_data;
    assign addr_w[g]   = bus.flash_addr;
    assign grant_w[g]  = grant_l;
    assign retry_w[g]  = retry_l;
    assign busy_w[g]   = busy_m;
    assign rises_w[g]  = rises;
    assign aacks_w[g]  = aacks;
    assign starts_w[g] = starts;
    assign viol_w[g]   = viol;
    assign order_w[g]  = ord;
  end

  task automatic wait_a_ack(input int g, input int maxc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (a_ack_w[g]) seen = 1'b1;
    end
  endtask

  task automatic set_a(input logic req, input logic [21:0] addr);
    for (int g = 0; g < 2; g++) begin
      a_req[g]  = req;
      a_addr[g] = addr;
    end
  endtask

  task automatic test_reset();
    for (int g = 0; g < 2; g++) begin
      a_req[g] = 1'b0; b_req[g] = 1'b0;
      a_addr[g] = '0;  b_addr[g] = '0;
      ignore_upto[g] = 0;
    end
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    ntests++; if (cs_w[0] !== 1'b0) begin nfail++; $display("FAIL reset_cs got=%b exp=0", cs_w[0]); end
    ntests++; if (addr_w[0] !== 22'h0) begin nfail++; $display("FAIL reset_addr got=%h exp=0", addr_w[0]); end
    ntests++; if (a_ack_w[0] !== 1'b0 || b_ack_w[0] !== 1'b0) begin nfail++; $display("FAIL reset_ack got=%b%b exp=00", a_ack_w[0], b_ack_w[0]); end
    ntests++; if (a_data_w[0] !== 16'h0 || b_data_w[0] !== 16'h0) begin nfail++; $display("FAIL reset_data got=%h/%h exp=0/0", a_data_w[0], b_data_w[0]); end
    ntests++; if (grant_w[0] !== 1'b0) begin nfail++; $display("FAIL reset_grant got=%b exp=0", grant_w[0]); end
    ntests++; if (retry_w[0] !== 8'h0) begin nfail++; $display("FAIL reset_retry got=%0d exp=0", retry_w[0]); end
    resetn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    int r0, a0;
    bit seen;
    r0 = rises_w[0]; a0 = aacks_w[0];
    set_a(1'b1, 22'h000123);
    @(negedge clk);
    ntests++; if (cs_w[0] !== 1'b1) begin nfail++; $display("FAIL single_cs_latency got=%b exp=1", cs_w[0]); end
    ntests++; if (addr_w[0] !== 22'h000123) begin nfail++; $display("FAIL single_addr got=%h exp=000123", addr_w[0]); end
    wait_a_ack(0, 60, seen);
    ntests++; if (seen !== 1'b1) begin nfail++; $display("FAIL single_ack_timeout got=%b exp=1", seen); end
    ntests++; if (a_data_w[0] !== 16'hBEEF) begin nfail++; $display("FAIL single_data got=%h exp=beef", a_data_w[0]); end
    ntests++; if (b_ack_w[0] !== 1'b0) begin nfail++; $display("FAIL single_b_ack got=%b exp=0", b_ack_w[0]); end
    set_a(1'b0, 22'h0);
    repeat (5) @(negedge clk);
    ntests++; if (rises_w[0] - r0 !== 1) begin nfail++; $display("FAIL single_cs_rises got=%0d exp=1", rises_w[0] - r0); end
    ntests++; if (aacks_w[0] - a0 !== 1) begin nfail++; $display("FAIL single_ack_count got=%0d exp=1", aacks_w[0] - a0); end
  endtask

  task automatic test_fairness();
    int ac [2];
    bit busy_any;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      ac[g] = 0;
      a_req[g] = 1'b1; a_addr[g] = 22'h10;
      b_req[g] = 1'b1; b_addr[g] = 22'h20;
    end
    busy_any = 1'b1;
    for (int c = 0; c < 300 && busy_any; c++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (a_ack_w[g]) begin
          ac[g]++;
          ntests++;
          if (a_data_w[g] !== (ac[g] == 1 ? 16'h5A4A : 16'h5A6A)) begin
            nfail++; $display("FAIL fair_a_data inst=%0d n=%0d got=%h", g, ac[g], a_data_w[g]);
          end
          if (ac[g] == 1) a_addr[g] = 22'h30;
          else            a_req[g]  = 1'b0;
        end
        if (b_ack_w[g]) begin
          ntests++;
          if (b_data_w[g] !== 16'h5A7A) begin nfail++; $display("FAIL fair_b_data inst=%0d got=%h exp=5a7a", g, b_data_w[g]); end
          b_req[g] = 1'b0;
        end
      end
      busy_any = a_req[0] | a_req[1] | b_req[0] | b_req[1];
    end
    ntests++; if (busy_any !== 1'b0) begin nfail++; $display("FAIL fair_timeout got=%b exp=0", busy_any); end
    repeat (2) @(negedge clk);
    ntests++; if (order_w[0] !== 6'b01_10_01) begin nfail++; $display("FAIL fair_rr_order got=%b exp=011001 (A,B,A)", order_w[0]); end
    ntests++; if (order_w[1] !== 6'b01_01_10) begin nfail++; $display("FAIL fair_fixed_order got=%b exp=010110 (A,A,B)", order_w[1]); end
  endtask

  task automatic test_retry();
    int r0, hc, lc, wc;
    bit seen;
    for (int g = 0; g < 2; g++) ignore_upto[g] = starts_w[g] + 1;
    r0 = rises_w[0];
    set_a(1'b1, 22'h000077);
    wc = 0;
    while (!cs_w[0] && wc < 10) begin @(negedge clk); wc++; end
    hc = 0;
    while (cs_w[0] && hc < 40) begin hc++; @(negedge clk); end
    ntests++; if (hc !== 8) begin nfail++; $display("FAIL retry_cs_high got=%0d exp=8", hc); end
    ntests++; if (retry_w[0] !== 8'd1) begin nfail++; $display("FAIL retry_cnt got=%0d exp=1", retry_w[0]); end
    lc = 0;
    while (!cs_w[0] && lc < 40) begin lc++; @(negedge clk); end
    ntests++; if (!(lc >= 2 && lc < 10)) begin nfail++; $display("FAIL retry_cs_low got=%0d exp=2..9", lc); end
    ntests++; if (addr_w[0] !== 22'h000077) begin nfail++; $display("FAIL retry_addr got=%h exp=000077", addr_w[0]); end
    wait_a_ack(0, 60, seen);
    ntests++; if (seen !== 1'b1) begin nfail++; $display("FAIL retry_ack_timeout got=%b exp=1", seen); end
    ntests++; if (a_data_w[0] !== 16'h5A2D) begin nfail++; $display("FAIL retry_data got=%h exp=5a2d", a_data_w[0]); end
    set_a(1'b0, 22'h0);
    repeat (4) @(negedge clk);
    ntests++; if (rises_w[0] - r0 !== 2) begin nfail++; $display("FAIL retry_cs_rises got=%0d exp=2", rises_w[0] - r0); end
    ntests++; if (viol_w[0] !== 0) begin nfail++; $display("FAIL cs_gap_violations got=%0d exp=0", viol_w[0]); end
  endtask

  task automatic test_not_ready();
    int a0;
    bit saw_cs, started, seen;
    a0 = aacks_w[0];
    ready = 1'b0;
    set_a(1'b1, 22'h000099);
    saw_cs = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (cs_w[0]) saw_cs = 1'b1;
    end
    ntests++; if (saw_cs !== 1'b0) begin nfail++; $display("FAIL notready_cs got=%b exp=0", saw_cs); end
    ntests++; if (aacks_w[0] - a0 !== 0) begin nfail++; $display("FAIL notready_ack got=%0d exp=0", aacks_w[0] - a0); end
    ready = 1'b1;
    started = 1'b0;
    for (int i = 0; i < 2 && !started; i++) begin
      @(negedge clk);
      if (cs_w[0]) started = 1'b1;
    end
    ntests++; if (started !== 1'b1) begin nfail++; $display("FAIL ready_start got=%b exp=1", started); end
    wait_a_ack(0, 60, seen);
    ntests++; if (seen !== 1'b1 || a_data_w[0] !== 16'h5AC3) begin nfail++; $display("FAIL ready_data got=%b/%h exp=1/5ac3", seen, a_data_w[0]); end
    set_a(1'b0, 22'h0);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int wc, a0;
    bit seen;
    set_a(1'b1, 22'h000044);
    wc = 0;
    while (!busy_w[0] && wc < 30) begin @(negedge clk); wc++; end
    @(negedge clk);
    resetn = 1'b0;
    #1;
    ntests++; if (cs_w[0] !== 1'b0) begin nfail++; $display("FAIL midreset_cs got=%b exp=0", cs_w[0]); end
    ntests++; if (a_ack_w[0] !== 1'b0 || a_data_w[0] !== 16'h0) begin nfail++; $display("FAIL midreset_a got=%b/%h exp=0/0", a_ack_w[0], a_data_w[0]); end
    ntests++; if (addr_w[0] !== 22'h0 || retry_w[0] !== 8'h0) begin nfail++; $display("FAIL midreset_regs got=%h/%0d exp=0/0", addr_w[0], retry_w[0]); end
    set_a(1'b0, 22'h0);
    @(negedge clk);
    resetn = 1'b1;
    wc = 0;
    while (busy_w[0] && wc < 30) begin @(negedge clk); wc++; end
    repeat (4) @(negedge clk);
    a0 = aacks_w[0];
    set_a(1'b1, 22'h000046);
    wait_a_ack(0, 60, seen);
    ntests++; if (seen !== 1'b1 || a_data_w[0] !== 16'h5A1C) begin nfail++; $display("FAIL postreset_data got=%b/%h exp=1/5a1c", seen, a_data_w[0]); end
    set_a(1'b0, 22'h0);
    repeat (4) @(negedge clk);
    ntests++; if (aacks_w[0] - a0 !== 1) begin nfail++; $display("FAIL postreset_ack_count got=%0d exp=1", aacks_w[0] - a0); end
  endtask

  task automatic test_cache();
    int r0;
    bit seen;
    r0 = rises_w[0];
    set_a(1'b1, 22'h000055);
    wait_a_ack(0, 60, seen);
    ntests++; if (seen !== 1'b1 || a_data_w[0] !== 16'h5A0F) begin nfail++; $display("FAIL cache_first got=%b/%h exp=1/5a0f", seen, a_data_w[0]); end
    set_a(1'b0, 22'h0);
    repeat (4) @(negedge clk);
    set_a(1'b1, 22'h000055);
    @(negedge clk);
`ifdef FLASH_ARB_CACHE_EN
    ntests++; if (a_ack_w[0] !== 1'b1) begin nfail++; $display("FAIL cache_hit_latency got=%b exp=1", a_ack_w[0]); end
    ntests++; if (a_data_w[0] !== 16'h5A0F) begin nfail++; $display("FAIL cache_hit_data got=%h exp=5a0f", a_data_w[0]); end
    set_a(1'b0, 22'h0);
    repeat (4) @(negedge clk);
    ntests++; if (rises_w[0] - r0 !== 1) begin nfail++; $display("FAIL cache_cs_rises got=%0d exp=1", rises_w[0] - r0); end
`else
    ntests++; if (a_ack_w[0] !== 1'b0) begin nfail++; $display("FAIL nocache_early_ack got=%b exp=0", a_ack_w[0]); end
    wait_a_ack(0, 60, seen);
    ntests++; if (seen !== 1'b1 || a_data_w[0] !== 16'h5A0F) begin nfail++; $display("FAIL nocache_second got=%b/%h exp=1/5a0f", seen, a_data_w[0]); end
    set_a(1'b0, 22'h0);
    repeat (4) @(negedge clk);
    ntests++; if (rises_w[0] - r0 !== 2) begin nfail++; $display("FAIL nocache_cs_rises got=%0d exp=2", rises_w[0] - r0); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_retry();
    test_not_ready();
    test_reset_mid();
    test_cache();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
